// File: rtl/wam_if.sv
// Whack-a-mole player-facing signals: taps and paddles in, lit holes and status out.
// The master drives the player inputs and the slave is the game controller.
interface wam_if;
   logic [7:0]  tap;
   logic        lft;
   logic        rgt;
   logic [7:0]  holes;
   logic [3:0]  hrdn;
   logic [11:0] score;
   logic        cout0;

   modport master (output tap, lft, rgt, input  holes, hrdn, score, cout0);
   modport slave  (input  tap, lft, rgt, output holes, hrdn, score, cout0);
endinterface

// File: rtl/wam_ctl.sv
// Whack-a-mole game controller: LFSR mole placement, BCD score, hardness control.
// All outputs are registered, and one shared timer covers both the mole-up window and the gap.
module wam_ctl #(
   parameter int GAP_CYC   = 4,
   parameter int MAX_MISS  = 3,
   parameter int HRDN_INIT = 1
) (
   input  logic clk_19,
   input  logic rst,
   wam_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_UP, S_GAP, S_OVER} state_t;

   localparam logic [7:0] L_MAX_MISS = 8'(MAX_MISS);
   localparam logic [4:0] L_GAP_LD   = 5'(GAP_CYC - 1);

   state_t      r_state;
   logic [7:0]  r_lfsr;
   logic [7:0]  r_holes;
   logic [3:0]  r_hrdn;
   logic [11:0] r_score;
   logic        r_cout0;
   logic [7:0]  r_miss;
   logic [4:0]  r_timer;
   logic [2:0]  r_prev;

   logic        w_hit, w_wrong, w_expire, w_miss_end, w_sat, w_wrap;
   logic [2:0]  w_idx;
   logic [7:0]  w_miss_nxt, w_lfsr_nxt;
   logic [11:0] w_score_inc;

   always_comb begin
      w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      w_idx      = (r_lfsr[2:0] == r_prev) ? r_lfsr[2:0] + 3'd1 : r_lfsr[2:0];
      w_hit      = |(bus.tap & r_holes);
      w_wrong    = (bus.tap != 8'h00) && !w_hit;
      // Timer is checked before its decrement, so 1 here means it reaches 0 on this edge
      w_expire   = (r_timer == 5'd1);
      w_miss_nxt = r_miss + 8'd1;
      w_miss_end = (w_miss_nxt >= L_MAX_MISS);
      w_sat      = (r_score == 12'h999);
      w_wrap     = (r_score[3:0] == 4'd9);
      w_score_inc = r_score;
      if (!w_wrap) begin
         w_score_inc[3:0] = r_score[3:0] + 4'd1;
      end else begin
         w_score_inc[3:0] = 4'd0;
         if (r_score[7:4] != 4'd9) begin
            w_score_inc[7:4] = r_score[7:4] + 4'd1;
         end else begin
            w_score_inc[7:4]  = 4'd0;
            w_score_inc[11:8] = r_score[11:8] + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_19 or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_lfsr  <= 8'h01;
         r_holes <= 8'h00;
         r_hrdn  <= 4'(HRDN_INIT);
         r_score <= 12'h000;
         r_cout0 <= 1'b0;
         r_miss  <= 8'h00;
         r_timer <= 5'd0;
         r_prev  <= 3'd0;
      end else begin
         r_lfsr  <= w_lfsr_nxt;
         r_cout0 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_holes <= 8'h00;
               if (bus.lft && !bus.rgt && r_hrdn > 4'd1)
                  r_hrdn <= r_hrdn - 4'd1;
               else if (bus.rgt && !bus.lft && r_hrdn < 4'd9)
                  r_hrdn <= r_hrdn + 4'd1;
               if (bus.tap != 8'h00) begin
                  r_score <= 12'h000;
                  r_miss  <= 8'h00;
                  r_state <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               r_holes <= 8'h01 << w_idx;
               r_prev  <= w_idx;
               r_timer <= 5'd20 - {r_hrdn, 1'b0};
               r_state <= S_UP;
            end
            S_UP: begin
               r_timer <= r_timer - 5'd1;
               if (w_hit) begin
                  r_holes <= 8'h00;
                  r_timer <= L_GAP_LD;
                  r_state <= S_GAP;
                  if (!w_sat) begin
                     r_score <= w_score_inc;
                     if (w_wrap && r_hrdn < 4'd9) begin
                        r_hrdn  <= r_hrdn + 4'd1;
                        r_cout0 <= 1'b1;
                     end
                  end
               end else if (w_wrong || w_expire) begin
                  // A wrong tap and an expiry in the same cycle still cost a single miss
                  r_miss <= w_miss_nxt;
                  if (w_miss_end) begin
                     r_holes <= 8'hFF;
                     r_state <= S_OVER;
                  end else if (w_expire) begin
                     r_holes <= 8'h00;
                     r_timer <= L_GAP_LD;
                     r_state <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (r_timer == 5'd0) r_state <= S_SPAWN;
               else                 r_timer <= r_timer - 5'd1;
            end
            S_OVER: begin
               r_holes <= 8'hFF;
               if (bus.lft || bus.rgt) begin
                  r_holes <= 8'h00;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.holes = r_holes;
   assign bus.hrdn  = r_hrdn;
   assign bus.score = r_score;
   assign bus.cout0 = r_cout0;
endmodule

// File: tb/tb_wam_ctl.sv
// Randomized bench for wam_ctl against a points/phase-level game model.
// The model keeps the score as an integer 0..999 and converts it to BCD only for comparison.
module tb_wam_ctl;
   localparam int GAP_CYC = 4, MAX_MISS = 3, HRDN_INIT = 1;
   localparam int P_IDLE = 0, P_SPAWN = 1, P_UP = 2, P_GAP = 3, P_OVER = 4;
   localparam logic [24:0] RST_V = {8'h00, 4'd1, 12'h000, 1'b0};

   logic clk_19 = 1'b0;
   logic rst    = 1'b1;
   wam_if bus();

   wam_ctl #(.GAP_CYC(GAP_CYC), .MAX_MISS(MAX_MISS), .HRDN_INIT(HRDN_INIT)) dut (
      .clk_19(clk_19), .rst(rst), .bus(bus));

   always #5 clk_19 = ~clk_19;

   int checks = 0, failures = 0, cout_seen = 0;
   int m_ph, m_pts, m_hr, m_miss, m_left, m_prev;
   logic [7:0] m_lfsr, m_lit;
   logic m_cout;
   logic [24:0] dut_v;
   assign dut_v = {bus.holes, bus.hrdn, bus.score, bus.cout0};

   always @(negedge clk_19) if (bus.cout0 === 1'b1) cout_seen++;

   function automatic logic [11:0] bcd(input int p);
      return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
   endfunction

   function automatic logic [24:0] m_exp();
      return {m_lit, 4'(m_hr), bcd(m_pts), m_cout};
   endfunction

   task automatic model_reset();
      m_ph = P_IDLE; m_pts = 0; m_hr = HRDN_INIT; m_miss = 0; m_left = 0; m_prev = 0;
      m_lfsr = 8'h01; m_lit = 8'h00; m_cout = 1'b0;
   endtask

   task automatic step(input logic [7:0] t, input logic l, input logic r);
      int idx;
      bus.tap = t; bus.lft = l; bus.rgt = r;
      m_cout = 1'b0;
      case (m_ph)
         P_IDLE: begin
            if (l && !r && m_hr > 1) m_hr--;
            else if (r && !l && m_hr < 9) m_hr++;
            if (t != 0) begin m_pts = 0; m_miss = 0; m_ph = P_SPAWN; end
         end
         P_SPAWN: begin
            idx = int'(m_lfsr % 8);
            if (idx == m_prev) idx = (idx + 1) % 8;
            m_prev = idx; m_lit = 8'(1 << idx); m_left = 20 - 2 * m_hr; m_ph = P_UP;
         end
         P_UP: begin
            m_left--;
            if ((t & m_lit) != 0) begin
               if (m_pts < 999) begin
                  m_pts++;
                  if (m_pts % 10 == 0 && m_hr < 9) begin m_hr++; m_cout = 1'b1; end
               end
               m_lit = 8'h00; m_left = GAP_CYC; m_ph = P_GAP;
            end else if (t != 0 || m_left == 0) begin
               m_miss++;
               if (m_miss >= MAX_MISS) begin m_lit = 8'hFF; m_ph = P_OVER; end
               else if (m_left == 0) begin m_lit = 8'h00; m_left = GAP_CYC; m_ph = P_GAP; end
            end
         end
         P_GAP: begin m_left--; if (m_left == 0) m_ph = P_SPAWN; end
         default: if (l || r) begin m_lit = 8'h00; m_ph = P_IDLE; end
      endcase
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      @(posedge clk_19); #1;
   endtask

   // Stimulus only: wait for a mole, optionally linger one cycle, then hit it (sometimes with extra bits)
   task automatic hit_once();
      int w;
      logic [7:0] x;
      w = 0;
      while (m_ph != P_UP && w < 20) begin step(8'h00, 1'b0, 1'b0); w++; end
      if ($urandom_range(0, 1) == 1) step(8'h00, 1'b0, 1'b0);
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(m_lit | x, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      bus.tap = 8'h00; bus.lft = 1'b0; bus.rgt = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_19);
      #1;
      checks++;
      if (dut_v !== RST_V) begin failures++; $display("FAIL reset_state: got %h want %h", dut_v, RST_V); end
      rst = 1'b0;
   endtask

   task automatic test_hardness();
      int exp_h[5] = '{1, 1, 2, 3, 4};
      for (int i = 0; i < 5; i++) begin
         step(8'h00, i < 2, i >= 2);
         checks++;
         if (bus.hrdn !== 4'(exp_h[i])) begin failures++; $display("FAIL hrdn_adjust%0d: got %0d want %0d", i, bus.hrdn, exp_h[i]); end
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL idle_model%0d: got %h want %h", i, dut_v, m_exp()); end
      end
      step(8'h00, 1'b1, 1'b1);
      checks++;
      if (bus.hrdn !== 4'd4) begin failures++; $display("FAIL hrdn_both: got %0d want 4", bus.hrdn); end
   endtask

   task automatic test_timeout();
      logic [7:0] first;
      int lit_cyc, dark, w;
      step(8'h10, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      first = bus.holes;
      checks++;
      if (dut_v !== m_exp() || $countones(first) != 1) begin failures++; $display("FAIL spawn_onehot: got %h want %h", dut_v, m_exp()); end
      lit_cyc = 0;
      while (bus.holes !== 8'h00 && lit_cyc < 40) begin lit_cyc++; step(8'h00, 1'b0, 1'b0); end
      checks++;
      if (lit_cyc !== 12) begin failures++; $display("FAIL up_window: got %0d want 12", lit_cyc); end
      dark = 0;
      while (bus.holes === 8'h00 && dark < 40) begin
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL gap_model: got %h want %h", dut_v, m_exp()); end
         dark++; step(8'h00, 1'b0, 1'b0);
      end
      // Four GAP cycles plus the SPAWN cycle are dark between moles
      checks++;
      if (dark !== GAP_CYC + 1) begin failures++; $display("FAIL gap_len: got %0d want %0d", dark, GAP_CYC + 1); end
      checks++;
      if (bus.holes === first || bus.holes !== m_lit) begin failures++; $display("FAIL next_index: got %h want %h (prev %h)", bus.holes, m_lit, first); end
      w = 0;
      while (m_ph != P_OVER && w < 100) begin
         step(8'h00, 1'b0, 1'b0); w++;
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL timeout_model: got %h want %h", dut_v, m_exp()); end
      end
      checks++;
      if (bus.holes !== 8'hFF) begin failures++; $display("FAIL timeout_over: got %h want ff", bus.holes); end
      step(8'h00, 1'b1, 1'b0);
      checks++;
      if (dut_v !== {8'h00, 4'd4, bcd(0), 1'b0}) begin failures++; $display("FAIL over_lft_exit: got %h want %h", dut_v, {8'h00, 4'd4, 12'h000, 1'b0}); end
   endtask

   task automatic test_wrong_taps();
      logic [7:0] x;
      int w;
      step(8'h01, 1'b0, 1'b0);
      w = 0;
      while (m_ph != P_UP && w < 20) begin step(8'h00, 1'b0, 1'b0); w++; end
      for (int i = 0; i < 3; i++) begin
         x = 8'($urandom_range(1, 255)) & ~m_lit;
         if (x == 8'h00) x = ~m_lit;
         step(x, 1'b0, 1'b0);
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL wrong_tap%0d: got %h want %h", i, dut_v, m_exp()); end
      end
      checks++;
      if (bus.holes !== 8'hFF || bus.score !== 12'h000) begin failures++; $display("FAIL wrong_over: got %h/%h want ff/000", bus.holes, bus.score); end
      repeat (3) step(8'($urandom), 1'b0, 1'b0);
      checks++;
      if (dut_v !== {8'hFF, 4'd4, 12'h000, 1'b0}) begin failures++; $display("FAIL over_ignores_tap: got %h want %h", dut_v, {8'hFF, 4'd4, 12'h000, 1'b0}); end
      step(8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.holes !== 8'h00 || bus.hrdn !== 4'd4) begin failures++; $display("FAIL over_rgt_exit: got %h/%0d want 00/4", bus.holes, bus.hrdn); end
   endtask

   task automatic test_hits();
      int c0;
      step(8'h80, 1'b0, 1'b0);
      c0 = cout_seen;
      for (int i = 0; i < 10; i++) begin
         hit_once();
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL hit%0d: got %h want %h", i, dut_v, m_exp()); end
      end
      checks++;
      if (bus.score !== 12'h010 || bus.hrdn !== 4'd5) begin failures++; $display("FAIL ten_hits: got %h/%0d want 010/5", bus.score, bus.hrdn); end
      repeat (2) step(8'h00, 1'b0, 1'b0);
      checks++;
      if (cout_seen - c0 !== 1) begin failures++; $display("FAIL cout0_pulse: got %0d want 1", cout_seen - c0); end
   endtask

   task automatic test_saturate();
      int n, c0;
      n = 0;
      while (m_pts < 999 && n < 1100) begin
         hit_once(); n++;
         checks++;
         if (dut_v !== m_exp()) begin failures++; $display("FAIL climb%0d: got %h want %h", m_pts, dut_v, m_exp()); end
      end
      checks++;
      if (bus.score !== 12'h999 || bus.hrdn !== 4'd9) begin failures++; $display("FAIL at_999: got %h/%0d want 999/9", bus.score, bus.hrdn); end
      c0 = cout_seen;
      hit_once();
      checks++;
      if (bus.score !== 12'h999 || bus.cout0 !== 1'b0) begin failures++; $display("FAIL sat_hit: got %h/%b want 999/0", bus.score, bus.cout0); end
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (cout_seen !== c0) begin failures++; $display("FAIL sat_cout: got %0d want %0d", cout_seen, c0); end
   endtask

   task automatic test_reset_mid();
      int w;
      w = 0;
      while (m_ph != P_OVER && w < 400) begin step(8'h00, 1'b0, 1'b0); w++; end
      step(8'h00, 1'b0, 1'b1);
      step(8'h04, 1'b0, 1'b0);
      for (int i = 0; i < 57; i++) hit_once();
      w = 0;
      while (m_ph != P_UP && w < 20) begin step(8'h00, 1'b0, 1'b0); w++; end
      checks++;
      if (dut_v !== m_exp() || bus.score !== 12'h057) begin failures++; $display("FAIL pre_reset: got %h want %h", dut_v, m_exp()); end
      bus.tap = 8'h00; bus.lft = 1'b0; bus.rgt = 1'b0;
      #3 rst = 1'b1;
      #1;
      checks++;
      if (dut_v !== RST_V) begin failures++; $display("FAIL async_reset: got %h want %h", dut_v, RST_V); end
      @(posedge clk_19); #1;
      rst = 1'b0;
      model_reset();
      step(8'h00, 1'b0, 1'b1);
      checks++;
      if (dut_v !== {8'h00, 4'd2, 12'h000, 1'b0}) begin failures++; $display("FAIL post_reset_idle: got %h want %h", dut_v, {8'h00, 4'd2, 12'h000, 1'b0}); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hardness();
      test_timeout();
      test_wrong_taps();
      test_hits();
      test_saturate();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
